mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_rr.sv | 36 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port to byte-RAM arbiter: request codes,
// FSM state encoding and port indices.
package mem_arbiter_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_TAIL = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // 11 is deliberately not a request, same as 00.
  function automatic logic is_req(input logic [1:0] flag);
    return (flag == RW_READ) || (flag == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-port round-robin grant: a lone requester wins, a tie goes to the
// port that was not granted last. The last-grant register updates on grant_fire.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_fire,
  output logic       grant_valid,
  output logic       grant_port
);

  logic last_grant;

  assign grant_valid = |req;

  always_comb begin
    grant_port = PORT0;
    if (req == 2'b11) begin
      grant_port = ~last_grant;
    end else if (req[1]) begin
      grant_port = PORT1;
    end
  end

  // Reset to port1 so port0 is the first winner of a tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT1;
    end else if (grant_fire) begin
      last_grant <= grant_port;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes two 32-bit ports (dcache=port0, icache=port1) onto a byte-wide
// RAM, one 4-byte transaction at a time; all outputs are registered.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rw_flag_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic [63:0] r_data_o,
  output logic [1:0]  busy_o,
  output logic [1:0]  done_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_w_data_o,
  input  logic [7:0]  ram_r_data_i,
  output logic [2:0]  fsm_state
);

  // Handshake: a port holds rw_flag until it sees busy_o; everything is
  // latched at grant, so later changes on that port are ignored until done_o.
  state_t      state;
  logic [1:0]  req;
  logic        grant_valid;
  logic        grant_port;
  logic        grant_fire;

  logic        cur_port;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_mask;
  logic [1:0]  k;
  logic [1:0]  k_next;
  logic [31:0] next_addr;
  logic [23:0] rd_buf;

  logic [1:0]  sel_flag;
  logic [31:0] sel_addr;
  logic [31:0] sel_data;
  logic [3:0]  sel_mask;

  assign req[0] = is_req(rw_flag_i[1:0]);
  assign req[1] = is_req(rw_flag_i[3:2]);

  assign grant_fire = (state == ST_IDLE) && grant_valid;
  assign fsm_state  = state;

  mem_arbiter_rr u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_fire  (grant_fire),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    sel_flag = rw_flag_i[1:0];
    sel_addr = addr_i[31:0];
    sel_data = w_data_i[31:0];
    sel_mask = w_mask_i[3:0];
    if (grant_port == PORT1) begin
      sel_flag = rw_flag_i[3:2];
      sel_addr = addr_i[63:32];
      sel_data = w_data_i[63:32];
      sel_mask = w_mask_i[7:4];
    end
  end

  // Byte offset wraps naturally modulo 2^32.
  assign k_next    = k + 2'd1;
  assign next_addr = cur_addr + {30'd0, k_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy_o       <= 2'b00;
      done_o       <= 2'b00;
      ram_addr_o   <= 32'd0;
      ram_we_o     <= 1'b0;
      ram_w_data_o <= 8'd0;
      r_data_o     <= 64'd0;
      cur_port     <= PORT0;
      cur_addr     <= 32'd0;
      cur_data     <= 32'd0;
      cur_mask     <= 4'd0;
      k            <= 2'd0;
      rd_buf       <= 24'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o   <= 2'b00;
          busy_o   <= 2'b00;
          ram_we_o <= 1'b0;
          if (grant_fire) begin
            cur_port   <= grant_port;
            cur_addr   <= sel_addr;
            cur_data   <= sel_data;
            cur_mask   <= sel_mask;
            k          <= 2'd0;
            ram_addr_o <= sel_addr;
            busy_o     <= (grant_port == PORT1) ? 2'b10 : 2'b01;
            if (sel_flag == RW_WRITE) begin
              ram_we_o     <= sel_mask[0];
              ram_w_data_o <= sel_data[7:0];
              state        <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          // RAM data lags the address by one cycle, so the byte for k-1 arrives now.
          if (k != 2'd0) begin
            rd_buf <= {ram_r_data_i, rd_buf[23:8]};
          end
          if (k == 2'd3) begin
            state <= ST_RD_TAIL;
          end else begin
            k          <= k_next;
            ram_addr_o <= next_addr;
          end
        end
        ST_RD_TAIL: begin
          if (cur_port == PORT1) begin
            r_data_o[63:32] <= {ram_r_data_i, rd_buf};
          end else begin
            r_data_o[31:0] <= {ram_r_data_i, rd_buf};
          end
          done_o <= busy_o;
          state  <= ST_DONE;
        end
        ST_WR: begin
          if (k == 2'd3) begin
            ram_we_o <= 1'b0;
            done_o   <= busy_o;
            state    <= ST_DONE;
          end else begin
            k            <= k_next;
            ram_addr_o   <= next_addr;
            ram_we_o     <= cur_mask[k_next];
            ram_w_data_o <= cur_data[8*k_next +: 8];
          end
        end
        ST_DONE: begin
          done_o <= 2'b00;
          busy_o <= 2'b00;
          state  <= ST_IDLE;
        end
        default: begin
          ram_we_o <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-RAM model with write log, one task per
// scenario, inline comparisons against hand-computed values.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  rw_flag_i;
  logic [63:0] addr_i;
  logic [63:0] w_data_i;
  logic [7:0]  w_mask_i;
  logic [63:0] r_data_o;
  logic [1:0]  busy_o;
  logic [1:0]  done_o;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_w_data_o;
  logic [7:0]  ram_r_data_i;
  logic [2:0]  fsm_state;

  int checks;
  int failures;

  logic [7:0]  mem [logic [31:0]];
  logic [39:0] wr_log[$];
  logic [39:0] exp_q[$];

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .rw_flag_i    (rw_flag_i),
    .addr_i       (addr_i),
    .w_data_i     (w_data_i),
    .w_mask_i     (w_mask_i),
    .r_data_o     (r_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ram_addr_o   (ram_addr_o),
    .ram_we_o     (ram_we_o),
    .ram_w_data_o (ram_w_data_o),
    .ram_r_data_i (ram_r_data_i),
    .fsm_state    (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM model: registered read, write on strobe, every write logged.
  always @(posedge clk) begin
    ram_r_data_i <= mem.exists(ram_addr_o) ? mem[ram_addr_o] : 8'h00;
    if (ram_we_o) begin
      mem[ram_addr_o] = ram_w_data_o;
      wr_log.push_back({ram_addr_o, ram_w_data_o});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_req();
    rw_flag_i = 4'b0000;
  endtask

  task automatic set_req(input int p, input logic [1:0] flag, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    if (p == 1) begin
      rw_flag_i[3:2]  = flag;
      addr_i[63:32]   = a;
      w_data_i[63:32] = d;
      w_mask_i[7:4]   = m;
    end else begin
      rw_flag_i[1:0] = flag;
      addr_i[31:0]   = a;
      w_data_i[31:0] = d;
      w_mask_i[3:0]  = m;
    end
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + 32'(i)] = w[8*i +: 8];
    end
  endtask

  // Full read on one port, checking addresses, busy, done and read data per cycle.
  task automatic run_read(input int p, input logic [31:0] a, input logic [31:0] exp_word);
    logic [1:0]  bit_p;
    logic [31:0] got;
    bit_p = (p == 1) ? 2'b10 : 2'b01;
    set_req(p, RW_READ, a, 32'h0, 4'h0);
    tick();
    // Changing the request after grant must not disturb the transaction.
    set_req(p, RW_NONE, a ^ 32'h5555_0000, 32'h0, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (busy_o !== bit_p) begin
        failures++;
        $display("FAIL rd_busy c=%0d got=%b exp=%b", c, busy_o, bit_p);
      end
      checks++;
      if (done_o !== ((c == 6) ? bit_p : 2'b00)) begin
        failures++;
        $display("FAIL rd_done c=%0d got=%b exp=%b", c, done_o, (c == 6) ? bit_p : 2'b00);
      end
      if (c <= 4) begin
        checks++;
        if (ram_addr_o !== a + 32'(c - 1) || ram_we_o !== 1'b0) begin
          failures++;
          $display("FAIL rd_addr c=%0d got=%h we=%b exp=%h", c, ram_addr_o, ram_we_o, a + 32'(c - 1));
        end
      end
      if (c == 6) begin
        got = (p == 1) ? r_data_o[63:32] : r_data_o[31:0];
        checks++;
        if (got !== exp_word) begin
          failures++;
          $display("FAIL rd_data port=%0d got=%h exp=%h", p, got, exp_word);
        end
      end
      tick();
    end
    checks++;
    if (busy_o !== 2'b00 || done_o !== 2'b00 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rd_after busy=%b done=%b state=%0d exp 00/00/0", busy_o, done_o, fsm_state);
    end
    clear_req();
  endtask

  task automatic test_reset();
    clear_req();
    addr_i = '0; w_data_i = '0; w_mask_i = '0;
    do_reset();
    checks++;
    if (busy_o !== 2'b00 || done_o !== 2'b00 || ram_we_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl busy=%b done=%b we=%b exp 00/00/0", busy_o, done_o, ram_we_o);
    end
    checks++;
    if (ram_addr_o !== 32'd0 || ram_w_data_o !== 8'd0) begin
      failures++;
      $display("FAIL reset_ram addr=%h wdata=%h exp 0/0", ram_addr_o, ram_w_data_o);
    end
    checks++;
    if (r_data_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", r_data_o);
    end
    checks++;
    if (fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", fsm_state);
    end
  endtask

  task automatic test_read_basic();
    load_word(32'h100, 32'h4433_2211);
    run_read(0, 32'h100, 32'h4433_2211);
  endtask

  task automatic test_write();
    int base;
    base = wr_log.size();
    exp_q.delete();
    exp_q.push_back({32'h200, 8'hDD});
    exp_q.push_back({32'h202, 8'hBB});
    set_req(1, RW_WRITE, 32'h200, 32'hAABB_CCDD, 4'b0101);
    tick();
    clear_req();
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (busy_o !== 2'b10 || done_o !== ((c == 5) ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL wr_ctl c=%0d busy=%b done=%b", c, busy_o, done_o);
      end
      if (c <= 4) begin
        checks++;
        if (ram_addr_o !== 32'h200 + 32'(c - 1) || ram_we_o !== ((c == 1 || c == 3) ? 1'b1 : 1'b0)) begin
          failures++;
          $display("FAIL wr_bus c=%0d addr=%h we=%b", c, ram_addr_o, ram_we_o);
        end
      end else begin
        checks++;
        if (ram_we_o !== 1'b0) begin
          failures++;
          $display("FAIL wr_done_we got=%b exp=0", ram_we_o);
        end
      end
      tick();
    end
    checks++;
    if (wr_log.size() - base != exp_q.size()) begin
      failures++;
      $display("FAIL wr_count got=%0d exp=%0d", wr_log.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[base + i] !== exp_q[i]) begin
          failures++;
          $display("FAIL wr_entry %0d got=%h exp=%h", i, wr_log[base + i], exp_q[i]);
        end
      end
    end
    checks++;
    if (r_data_o !== {32'h0, 32'h4433_2211}) begin
      failures++;
      $display("FAIL wr_rdata_kept got=%h exp=%h", r_data_o, {32'h0, 32'h4433_2211});
    end
  endtask

  task automatic test_wrap();
    load_word(32'hFFFF_FFFE, 32'hD4C3_B2A1);
    run_read(0, 32'hFFFF_FFFE, 32'hD4C3_B2A1);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_busy;
    logic [1:0] exp_done;
    int         waited;
    do_reset();
    load_word(32'h300, 32'hA4A3_A2A1);
    set_req(0, RW_READ, 32'h100, 32'h0, 4'h0);
    set_req(1, RW_READ, 32'h300, 32'h0, 4'h0);
    tick();
    for (int c = 1; c <= 13; c++) begin
      exp_busy = (c <= 6) ? 2'b01 : (c == 7) ? 2'b00 : 2'b10;
      exp_done = (c == 6) ? 2'b01 : (c == 13) ? 2'b10 : 2'b00;
      checks++;
      if (busy_o !== exp_busy || done_o !== exp_done) begin
        failures++;
        $display("FAIL rr_pair c=%0d busy=%b done=%b exp %b/%b", c, busy_o, done_o, exp_busy, exp_done);
      end
      if (c == 13) begin
        clear_req();
        checks++;
        if (r_data_o !== {32'hA4A3_A2A1, 32'h4433_2211}) begin
          failures++;
          $display("FAIL rr_rdata got=%h exp=%h", r_data_o, {32'hA4A3_A2A1, 32'h4433_2211});
        end
      end
      tick();
    end
    // A port0 grant leaves port1 as the next tie winner.
    run_read(0, 32'h100, 32'h4433_2211);
    set_req(0, RW_READ, 32'h100, 32'h0, 4'h0);
    set_req(1, RW_READ, 32'h300, 32'h0, 4'h0);
    tick();
    checks++;
    if (busy_o !== 2'b10) begin
      failures++;
      $display("FAIL rr_second_grant busy=%b exp=10", busy_o);
    end
    clear_req();
    waited = 0;
    while (done_o === 2'b00 && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (done_o !== 2'b10) begin
      failures++;
      $display("FAIL rr_second_done got=%b exp=10 waited=%0d", done_o, waited);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int base;
    base = wr_log.size();
    exp_q.delete();
    exp_q.push_back({32'h400, 8'h0D});
    exp_q.push_back({32'h401, 8'h0C});
    set_req(0, RW_WRITE, 32'h400, 32'h0A0B_0C0D, 4'b1111);
    tick();
    clear_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (fsm_state !== ST_IDLE || busy_o !== 2'b00) begin
      failures++;
      $display("FAIL abort_idle state=%0d busy=%b exp 0/00", fsm_state, busy_o);
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (ram_we_o !== 1'b0 || done_o !== 2'b00) begin
        failures++;
        $display("FAIL abort_quiet c=%0d we=%b done=%b", c, ram_we_o, done_o);
      end
      tick();
    end
    checks++;
    if (wr_log.size() - base != exp_q.size()) begin
      failures++;
      $display("FAIL abort_wr_count got=%0d exp=%0d", wr_log.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[base + i] !== exp_q[i]) begin
          failures++;
          $display("FAIL abort_wr_entry %0d got=%h exp=%h", i, wr_log[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_flag11();
    int base;
    base = wr_log.size();
    rw_flag_i = 4'b0011;
    addr_i[31:0] = 32'h500;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (busy_o !== 2'b00 || fsm_state !== ST_IDLE || ram_we_o !== 1'b0 || ram_addr_o !== 32'd0) begin
        failures++;
        $display("FAIL flag11 c=%0d busy=%b state=%0d we=%b addr=%h", c, busy_o, fsm_state, ram_we_o, ram_addr_o);
      end
    end
    checks++;
    if (wr_log.size() != base) begin
      failures++;
      $display("FAIL flag11_writes got=%0d exp=%0d", wr_log.size(), base);
    end
    clear_req();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_read_basic();
    test_write();
    test_wrap();
    test_round_robin();
    test_reset_abort();
    test_flag11();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
